spi_flash_responder: RTL and testbench

SPI mode-0 responder that emulates a serial NOR flash device for the console's flash reader. It decodes the READ (0x03) command plus a 24-bit address from the host and streams bytes MSB-first from an attached byte-wide memory, auto-incrementing the address. It sits on the far side of the flash pins and serves two purposes: a simulation model for the flash-reader bench, and an on-chip stand-in when external flash is absent.

---
 rtl/spi_flash_pkg.sv | 18 +
 rtl/spi_edge_sync.sv | 28 ++
 rtl/spi_flash_responder.sv | 163 ++++++++++++++++
 tb/tb_spi_flash_responder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_flash_pkg.sv
// Shared state encoding and opcode/address constants for the SPI flash responder.
package spi_flash_pkg;

    localparam int ADDR_W = 24;

    localparam logic [7:0] OP_READ      = 8'h03;
    localparam logic [7:0] OP_FAST_READ = 8'h0B;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA,
        ST_IGNORE
    } state_t;

endpackage

// File: rtl/spi_edge_sync.sv
// Synchronizer chain for one asynchronous input, with rise/fall pulses in the clk domain.
module spi_edge_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_rise = r_sync[STAGES-1] & ~r_prev;
    assign o_fall = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 serial NOR flash emulator: READ (and FAST_READ when SPI_FAST_READ_EN is
// defined) streams bytes MSB-first from a byte-wide memory with 1-cycle read latency.
module spi_flash_responder
    import spi_flash_pkg::*;
#(
    parameter int         SYNC_STAGES   = 2,
    parameter logic [7:0] CMD_READ      = OP_READ,
    parameter logic [7:0] CMD_FAST_READ = OP_FAST_READ
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spiClk,
    input  logic              spiCs,
    input  logic              spiMosi,
    output logic              spiMiso,
    output logic              spiMisoOe,
    output logic [ADDR_W-1:0] memAddr,
    output logic              memRd,
    input  logic [7:0]        memData,
    output logic              cmdErr,
    output logic              busy
);

`ifdef SPI_FAST_READ_EN
    localparam bit FAST_EN = 1'b1;
`else
    localparam bit FAST_EN = 1'b0;
`endif

    state_t r_state, w_next_state;

    logic [SYNC_STAGES-1:0] r_cs_sync, r_mosi_sync;
    logic                   w_cs, w_mosi, w_sck_rise, w_sck_fall;
    logic                   r_armed;
    logic [4:0]             r_bit_cnt;
    logic [ADDR_W-2:0]      r_shift_in;
    logic [ADDR_W-1:0]      r_mem_addr;
    logic [7:0]             r_shift_out, r_next_byte;
    logic                   r_mem_rd, r_rd_d1, r_cmd_err, r_fast;
    logic [7:0]             w_op;
    logic                   w_op_fast, w_op_ok;

    spi_edge_sync #(.STAGES(SYNC_STAGES)) u_sck_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_d    (spiClk),
        .o_rise (w_sck_rise),
        .o_fall (w_sck_fall)
    );

    // CS resets to "selected" so a frame in flight at reset never looks like a fresh CS fall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cs_sync   <= '0;
            r_mosi_sync <= '0;
        end else begin
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spiCs};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spiMosi};
        end
    end

    assign w_cs      = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi    = r_mosi_sync[SYNC_STAGES-1];
    assign w_op      = {r_shift_in[6:0], w_mosi};
    assign w_op_fast = FAST_EN && (w_op == CMD_FAST_READ);
    assign w_op_ok   = (w_op == CMD_READ) || w_op_fast;

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        if (w_cs) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  if (r_armed) w_next_state = ST_CMD;
                ST_CMD:   if (w_sck_rise && r_bit_cnt == 5'd7)
                              w_next_state = w_op_ok ? ST_ADDR : ST_IGNORE;
                ST_ADDR:  if (w_sck_rise && r_bit_cnt == 5'd23)
                              w_next_state = r_fast ? ST_DUMMY : ST_DATA;
                ST_DUMMY: if (w_sck_rise && r_bit_cnt == 5'd7) w_next_state = ST_DATA;
                default:  ;
            endcase
        end
    end

    always_comb begin
        spiMisoOe = (r_state == ST_DATA);
        spiMiso   = (r_state == ST_DATA) & r_shift_out[7];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_armed     <= 1'b0;
            r_bit_cnt   <= '0;
            r_shift_in  <= '0;
            r_mem_addr  <= '0;
            r_shift_out <= '0;
            r_next_byte <= '0;
            r_mem_rd    <= 1'b0;
            r_rd_d1     <= 1'b0;
            r_cmd_err   <= 1'b0;
            r_fast      <= 1'b0;
        end else begin
            r_mem_rd  <= 1'b0;
            r_cmd_err <= 1'b0;
            r_rd_d1   <= r_mem_rd;
            if (w_cs) r_armed <= 1'b1;
            if (w_cs || r_state == ST_IDLE) begin
                r_bit_cnt   <= '0;
                r_shift_out <= '0;
                r_fast      <= 1'b0;
            end else if (w_sck_rise) begin
                r_bit_cnt <= r_bit_cnt + 5'd1;
                case (r_state)
                    ST_CMD: begin
                        r_shift_in <= {r_shift_in[ADDR_W-3:0], w_mosi};
                        if (r_bit_cnt == 5'd7) begin
                            r_bit_cnt <= '0;
                            r_cmd_err <= ~w_op_ok;
                            r_fast    <= w_op_fast;
                        end
                    end
                    ST_ADDR: begin
                        r_shift_in <= {r_shift_in[ADDR_W-3:0], w_mosi};
                        if (r_bit_cnt == 5'd23) begin
                            r_bit_cnt  <= '0;
                            r_mem_addr <= {r_shift_in, w_mosi};
                            r_mem_rd   <= 1'b1;
                        end
                    end
                    ST_DUMMY: if (r_bit_cnt == 5'd7) r_bit_cnt <= '0;
                    default:  ;
                endcase
            end else if (w_sck_fall && r_state == ST_DATA) begin
                // Count 0 is the fall trailing the last address/dummy rise: bit 7 must stay put.
                if (r_bit_cnt == 5'd8) begin
                    r_shift_out <= r_next_byte;
                    r_bit_cnt   <= '0;
                end else if (r_bit_cnt != 5'd0) begin
                    r_shift_out <= {r_shift_out[6:0], 1'b0};
                    if (r_bit_cnt == 5'd7) begin
                        r_mem_addr <= r_mem_addr + 24'd1;
                        r_mem_rd   <= 1'b1;
                    end
                end
            end
            if (r_rd_d1 && (r_state == ST_DATA || r_state == ST_DUMMY)) begin
                if (r_bit_cnt == 5'd0) r_shift_out <= memData;
                else                   r_next_byte <= memData;
            end
        end
    end

    assign memAddr = r_mem_addr;
    assign memRd   = r_mem_rd;
    assign cmdErr  = r_cmd_err;
    assign busy    = r_armed & ~w_cs;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Scoreboard bench for spi_flash_responder: host tasks push expected bytes, read addresses
// and error pulses; pin monitors pop and compare as the responder produces them.
module tb_spi_flash_responder;

    localparam int HALF = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        spiClk = 1'b0;
    logic        spiCs = 1'b1;
    logic        spiMosi = 1'b0;
    logic        spiMiso, spiMisoOe, memRd, cmdErr, busy;
    logic [23:0] memAddr;
    logic [7:0]  memData;

    int total = 0;
    int bad = 0;

    logic [7:0]  exp_bytes[$];
    logic [23:0] exp_addrs[$];
    bit          exp_errs[$];

    int          mbits = 0;
    logic [7:0]  mbyte = 8'h00;

    spi_flash_responder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .spiClk    (spiClk),
        .spiCs     (spiCs),
        .spiMosi   (spiMosi),
        .spiMiso   (spiMiso),
        .spiMisoOe (spiMisoOe),
        .memAddr   (memAddr),
        .memRd     (memRd),
        .memData   (memData),
        .cmdErr    (cmdErr),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Memory preloaded with byte = addr[7:0], one cycle read latency.
    always @(posedge clk) if (memRd) memData <= memAddr[7:0];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        total++;
        bad++;
        $display("FAIL %s: got=%0h want=none", name, act);
    endtask

    always @(negedge clk) begin
        if (memRd) begin
            if (exp_addrs.size() == 0) unexpected("memrd_addr", memAddr);
            else begin
                logic [23:0] ea;
                ea = exp_addrs.pop_front();
                chk("memrd_addr", memAddr, ea);
                $display("memRd addr=%06h want=%06h", memAddr, ea);
            end
        end
        if (cmdErr) begin
            if (exp_errs.size() == 0) unexpected("cmd_err_pulse", cmdErr);
            else begin
                bit ee;
                ee = exp_errs.pop_front();
                chk("cmd_err_pulse", 32'(cmdErr), 32'(ee));
                $display("cmdErr pulse seen");
            end
        end
    end

    always @(posedge spiClk or posedge spiCs or negedge rst_n) begin
        if (spiCs || !rst_n) begin
            mbits = 0;
        end else if (spiMisoOe) begin
            mbyte = {mbyte[6:0], spiMiso};
            mbits++;
            if (mbits == 8) begin
                mbits = 0;
                if (exp_bytes.size() == 0) unexpected("miso_byte", mbyte);
                else begin
                    logic [7:0] eb;
                    eb = exp_bytes.pop_front();
                    chk("miso_byte", mbyte, eb);
                    $display("MISO byte=%02h want=%02h", mbyte, eb);
                end
            end
        end else begin
            chk("miso_idle_low", spiMiso, 1'b0);
        end
    end

    task automatic half();
        repeat (HALF) @(posedge clk);
        #2;
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            spiMosi = v[i];
            half();
            spiClk = 1'b1;
            half();
            spiClk = 1'b0;
        end
    endtask

    task automatic cs_low();
        spiCs = 1'b0;
        half();
        chk("busy_selected", busy, 1'b1);
    endtask

    task automatic cs_high();
        half();
        spiCs = 1'b1;
        repeat (12) @(posedge clk);
        #2;
        chk("busy_deselected", busy, 1'b0);
        chk("oe_deselected", spiMisoOe, 1'b0);
    endtask

    task automatic read_txn(input logic [7:0] op, input logic [23:0] addr, input int nbytes);
        cs_low();
        send_bits(32'(op), 8);
        send_bits(32'(addr), 24);
        for (int b = 0; b < nbytes; b++) send_bits(32'h0, 8);
        cs_high();
    endtask

    // A read of n bytes also prefetches one byte past the last one delivered.
    task automatic expect_read(input logic [23:0] a, input int n);
        for (int i = 0; i < n; i++) exp_bytes.push_back(8'(a + 24'(i)));
        for (int i = 0; i <= n; i++) exp_addrs.push_back(a + 24'(i));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_miso"}, spiMiso, 1'b0);
        chk({tag, "_oe"}, spiMisoOe, 1'b0);
        chk({tag, "_memrd"}, memRd, 1'b0);
        chk({tag, "_memaddr"}, memAddr, 24'h0);
        chk({tag, "_cmderr"}, cmdErr, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b1;
        chk_reset_outputs("rst");
        repeat (6) @(posedge clk);
        #2;

        // Basic read of 4 bytes at 0x000010
        exp_bytes.push_back(8'h10); exp_bytes.push_back(8'h11);
        exp_bytes.push_back(8'h12); exp_bytes.push_back(8'h13);
        exp_addrs.push_back(24'h000010); exp_addrs.push_back(24'h000011);
        exp_addrs.push_back(24'h000012); exp_addrs.push_back(24'h000013);
        exp_addrs.push_back(24'h000014);
        read_txn(8'h03, 24'h000010, 4);

        // Address wrap at the top of the 24-bit space
        exp_bytes.push_back(8'hFE); exp_bytes.push_back(8'hFF);
        exp_bytes.push_back(8'h00); exp_bytes.push_back(8'h01);
        exp_addrs.push_back(24'hFFFFFE); exp_addrs.push_back(24'hFFFFFF);
        exp_addrs.push_back(24'h000000); exp_addrs.push_back(24'h000001);
        exp_addrs.push_back(24'h000002);
        read_txn(8'h03, 24'hFFFFFE, 4);

        // Unsupported opcode, then a good read
        exp_errs.push_back(1'b1);
        cs_low();
        send_bits(32'h9F, 8);
        send_bits(32'h0, 16);
        chk("oe_after_bad_op", spiMisoOe, 1'b0);
        cs_high();
        expect_read(24'h000033, 1);
        read_txn(8'h03, 24'h000033, 1);

        // CS raised after 12 address bits, then full read
        cs_low();
        send_bits(32'h03, 8);
        send_bits(32'hABC, 12);
        cs_high();
        expect_read(24'h000020, 2);
        read_txn(8'h03, 24'h000020, 2);

        // Reset pulse mid-DATA
        exp_addrs.push_back(24'h000040);
        cs_low();
        send_bits(32'h03, 8);
        send_bits(32'h000040, 24);
        send_bits(32'h0, 3);
        rst_n = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        chk_reset_outputs("midrst");
        send_bits(32'h0, 8);
        chk("busy_after_midrst", busy, 1'b0);
        chk("oe_after_midrst", spiMisoOe, 1'b0);
        cs_high();
        expect_read(24'h000050, 1);
        read_txn(8'h03, 24'h000050, 1);

`ifdef SPI_FAST_READ_EN
        // Fast read with 8 dummy clocks
        exp_bytes.push_back(8'h05); exp_bytes.push_back(8'h06);
        exp_addrs.push_back(24'h000005); exp_addrs.push_back(24'h000006);
        exp_addrs.push_back(24'h000007);
        cs_low();
        send_bits(32'h0B, 8);
        send_bits(32'h000005, 24);
        send_bits(32'h0, 8);
        send_bits(32'h0, 8);
        send_bits(32'h0, 8);
        cs_high();
`else
        exp_errs.push_back(1'b1);
        cs_low();
        send_bits(32'h0B, 8);
        send_bits(32'h0, 8);
        chk("oe_after_fast_op", spiMisoOe, 1'b0);
        cs_high();
`endif

        repeat (10) @(posedge clk);
        #2;
        chk("bytes_left", exp_bytes.size(), 0);
        chk("addrs_left", exp_addrs.size(), 0);
        chk("errs_left", exp_errs.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
